rgmii_tx_ddr_if: RTL

- Transmit-side companion of the RGMII source-synchronous DDR input path.
- Accepts GMII bytes from the Ethernet MAC and handles 1000/100/10 speed selection, nibble serialisation, TX_CTL encoding and forwarded-clock pattern generation.
- Produces rising-edge/falling-edge pairs (q1/q2) for the per-pin DDR output registers instantiated at the ethernet top level.
- Also generates the GMII transmit clock enable that paces the MAC.

---
 rtl/rgmii_pkg.sv | 22 ++
 rtl/rgmii_tx_clk_gen.sv | 106 ++++++++++
 rtl/rgmii_tx_ddr_if.sv | 88 ++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared RGMII transmit definitions: speed modes, divider width
// and the speed_i decode used at byte boundaries.
package rgmii_pkg;

   typedef enum logic [1:0] {
      e_speed_10   = 2'b00,
      e_speed_100  = 2'b01,
      e_speed_1000 = 2'b10
   } speed_e;

   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   function automatic speed_e speed_decode(input logic [1:0] s);
      if (s[1])
         return e_speed_1000;
      else if (s[0])
         return e_speed_100;
      return e_speed_10;
   endfunction

endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// RGMII transmit timing: divider, nibble phase, speed latch,
// MAC clock enable and forwarded TXC pattern.
module rgmii_tx_clk_gen
   import rgmii_pkg::*;
#(
   parameter int DIV_100 = 5,
   parameter int DIV_10  = 50
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] speed,
   output logic       clk_en,
   output logic       mii_sel,
   output logic       nxt_mii,
   output logic       nxt_ph,
   output logic       txc_q1,
   output logic       txc_q2
);

   localparam logic [CNT_W-1:0] LAST_100 = CNT_W'(DIV_100 - 1);
   localparam logic [CNT_W-1:0] LAST_10  = CNT_W'(DIV_10 - 1);
   localparam logic [CNT_W-1:0] HALF_100 = CNT_W'(DIV_100 / 2);
   localparam logic [CNT_W-1:0] HALF_10  = CNT_W'(DIV_10 / 2);
   localparam logic ODD_100 = (DIV_100 % 2) == 1;
   localparam logic ODD_10  = (DIV_10 % 2) == 1;

   speed_e           mode;
   speed_e           nxt_mode;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt_cnt;
   logic             ph;
   logic             run;
   logic [CNT_W-1:0] last;
   logic [CNT_W-1:0] nlast;
   logic [CNT_W-1:0] nhalf;
   logic             nodd;
   logic             bound;
   logic             en_d;
   logic             txc1_d;
   logic             txc2_d;

   // mode/cnt/ph describe the current cycle; outputs are
   // registered from the next-cycle state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode    <= e_speed_1000;
         cnt     <= '0;
         ph      <= 1'b0;
         run     <= 1'b0;
         clk_en  <= 1'b0;
         mii_sel <= 1'b0;
         txc_q1  <= 1'b0;
         txc_q2  <= 1'b0;
      end else begin
         mode    <= nxt_mode;
         cnt     <= nxt_cnt;
         ph      <= nxt_ph;
         run     <= 1'b1;
         clk_en  <= en_d;
         mii_sel <= nxt_mii;
         txc_q1  <= txc1_d;
         txc_q2  <= txc2_d;
      end
   end

   always_comb begin
      last = (mode == e_speed_10) ? LAST_10 : LAST_100;
      bound = (mode == e_speed_1000) || (ph && (cnt == last));
      nxt_mode = mode;
      nxt_cnt = cnt + CNT_W'(1);
      nxt_ph = ph;
      if (!run) begin
         nxt_mode = e_speed_1000;
         nxt_cnt = '0;
         nxt_ph = 1'b0;
      end else if (bound) begin
         nxt_mode = speed_decode(speed);
         nxt_cnt = '0;
         nxt_ph = 1'b0;
      end else if (cnt == last) begin
         nxt_cnt = '0;
         nxt_ph = 1'b1;
      end
   end

   always_comb begin
      nlast = LAST_100;
      nhalf = HALF_100;
      nodd = ODD_100;
      if (nxt_mode == e_speed_10) begin
         nlast = LAST_10;
         nhalf = HALF_10;
         nodd = ODD_10;
      end
      nxt_mii = (nxt_mode != e_speed_1000);
      en_d = 1'b1;
      txc1_d = 1'b1;
      txc2_d = 1'b0;
      if (nxt_mii) begin
         en_d = nxt_ph && (nxt_cnt == nlast);
         txc2_d = (nxt_cnt < nhalf);
         txc1_d = txc2_d || (nodd && (nxt_cnt == nhalf));
      end
   end

endmodule

// File: rtl/rgmii_tx_ddr_if.sv
// RGMII transmit path: GMII byte capture and nibble/TX_CTL
// q1/q2 pairs for the external DDR output registers.
module rgmii_tx_ddr_if
   import rgmii_pkg::*;
#(
   parameter int DIV_100 = 5,
   parameter int DIV_10  = 50
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [1:0] speed_i,
   input  logic [7:0] gmii_txd_i,
   input  logic       gmii_tx_en_i,
   input  logic       gmii_tx_er_i,
   output logic       gmii_tx_clk_en_o,
   output logic       mii_select_o,
   output logic [3:0] txd_q1_o,
   output logic [3:0] txd_q2_o,
   output logic       tx_ctl_q1_o,
   output logic       tx_ctl_q2_o,
   output logic       txc_q1_o,
   output logic       txc_q2_o
);

   logic       nxt_mii;
   logic       nxt_ph;
   logic [7:0] txd_r;
   logic       en_r;
   logic       er_r;
   logic [7:0] txd_d;
   logic       en_d;
   logic       er_d;
   logic [3:0] lo_d;
   logic [3:0] hi_d;

   rgmii_tx_clk_gen #(
      .DIV_100 (DIV_100),
      .DIV_10  (DIV_10)
   ) u_clk_gen (
      .clk     (clk_i),
      .reset_n (reset_n_i),
      .speed   (speed_i),
      .clk_en  (gmii_tx_clk_en_o),
      .mii_sel (mii_select_o),
      .nxt_mii (nxt_mii),
      .nxt_ph  (nxt_ph),
      .txc_q1  (txc_q1_o),
      .txc_q2  (txc_q2_o)
   );

   // a byte being accepted this cycle drives the pairs directly
   always_comb begin
      txd_d = gmii_tx_clk_en_o ? gmii_txd_i : txd_r;
      en_d = gmii_tx_clk_en_o ? gmii_tx_en_i : en_r;
      er_d = gmii_tx_clk_en_o ? gmii_tx_er_i : er_r;
      lo_d = txd_d[3:0];
      hi_d = txd_d[7:4];
      if (nxt_mii) begin
         lo_d = nxt_ph ? txd_d[7:4] : txd_d[3:0];
         hi_d = lo_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         txd_r       <= '0;
         en_r        <= 1'b0;
         er_r        <= 1'b0;
         txd_q1_o    <= '0;
         txd_q2_o    <= '0;
         tx_ctl_q1_o <= 1'b0;
         tx_ctl_q2_o <= 1'b0;
      end else begin
         txd_r       <= txd_d;
         en_r        <= en_d;
         er_r        <= er_d;
         txd_q1_o    <= lo_d;
         txd_q2_o    <= hi_d;
         tx_ctl_q1_o <= en_d;
         tx_ctl_q2_o <= en_d ^ er_d;
      end
   end

   div_range: assert property (@(posedge clk_i)
      (DIV_100 >= 2) && (DIV_100 <= CNT_MAX) &&
      (DIV_10 >= 2) && (DIV_10 <= CNT_MAX));

endmodule
